// File: rtl/input1_loader.sv
// input1_loader
//   Host-side controller for the 8192 x 12-bit input-1 stream memory.
//   Parses a byte command stream from the host link, unpacks byte pairs into
//   12-bit words written to the memory, and sequences a CPU run while
//   tracking how many loaded words the CPU has consumed.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   rx_valid   : host byte available
//   rx_data    : host byte
//   rx_ready   : byte accepted when rx_valid & rx_ready
//   in1_write  : memory write strobe
//   addr_in    : memory write address (meaningful with in1_write)
//   data_in    : memory write data    (meaningful with in1_write)
//   mem_rst    : one-cycle pulse resetting the memory read pointer
//   adv1       : CPU advanced the input-1 read pointer
//   run        : CPU enable
//   loaded_len : word count of the last completed load
//   consumed   : words consumed in the current run (saturates at loaded_len)
//   in_empty   : run active and every loaded word consumed
//   busy       : load in progress
module input1_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        in1_write,
    output logic [12:0] addr_in,
    output logic [11:0] data_in,
    output logic        mem_rst,
    input  logic        adv1,
    output logic        run,
    output logic [12:0] loaded_len,
    output logic [12:0] consumed,
    output logic        in_empty,
    output logic        busy
);

    localparam logic [7:0] CMD_LOAD = 8'hA1;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STOP = 8'h53;

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA_LO, DATA_HI, WRITE, RST_PULSE, RUN
    } state_t;

    state_t      state_q, state_d;
    logic        rdy_en_q;
    logic [12:0] len_q, len_d;
    logic [12:0] idx_q, idx_d;
    logic [7:0]  lo_q, lo_d;
    logic [12:0] addr_q, addr_d;
    logic [11:0] data_q, data_d;
    logic [12:0] loaded_len_q, loaded_len_d;
    logic [12:0] consumed_q, consumed_d;
    logic        accept;

    // rdy_en_q keeps rx_ready low while reset is asserted even though the
    // reset state (IDLE) would otherwise accept bytes.
    assign rx_ready   = rdy_en_q && (state_q != WRITE) && (state_q != RST_PULSE);
    assign accept     = rx_valid && rx_ready;
    assign in1_write  = (state_q == WRITE);
    assign mem_rst    = (state_q == RST_PULSE);
    assign run        = (state_q == RUN);
    assign busy       = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                        (state_q == DATA_LO) || (state_q == DATA_HI) ||
                        (state_q == WRITE);
    assign in_empty   = (state_q == RUN) && (consumed_q == loaded_len_q);
    assign addr_in    = addr_q;
    assign data_in    = data_q;
    assign loaded_len = loaded_len_q;
    assign consumed   = consumed_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rdy_en_q     <= 1'b0;
            len_q        <= '0;
            idx_q        <= '0;
            lo_q         <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            loaded_len_q <= '0;
            consumed_q   <= '0;
        end else begin
            state_q      <= state_d;
            rdy_en_q     <= 1'b1;
            len_q        <= len_d;
            idx_q        <= idx_d;
            lo_q         <= lo_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            loaded_len_q <= loaded_len_d;
            consumed_q   <= consumed_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        lo_d         = lo_q;
        addr_d       = addr_q;
        data_d       = data_q;
        loaded_len_d = loaded_len_q;
        consumed_d   = consumed_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (rx_data == CMD_LOAD)     state_d = LEN_HI;
                    else if (rx_data == CMD_RUN) state_d = RST_PULSE;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d   = {rx_data[4:0], len_q[7:0]};
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d = {len_q[12:8], rx_data};
                    if ({len_q[12:8], rx_data} == 13'd0) begin
                        loaded_len_d = '0;
                        state_d      = IDLE;
                    end else begin
                        idx_d   = '0;
                        state_d = DATA_LO;
                    end
                end
            end
            DATA_LO: begin
                if (accept) begin
                    lo_d    = rx_data;
                    state_d = DATA_HI;
                end
            end
            DATA_HI: begin
                if (accept) begin
                    // Write port is registered here so it is stable for the
                    // whole WRITE cycle and holds afterwards.
                    addr_d  = idx_q;
                    data_d  = {rx_data[3:0], lo_q};
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (idx_q == len_q - 13'd1) begin
                    loaded_len_d = len_q;
                    state_d      = IDLE;
                end else begin
                    idx_d   = idx_q + 13'd1;
                    state_d = DATA_LO;
                end
            end
            RST_PULSE: begin
                consumed_d = '0;
                state_d    = RUN;
            end
            RUN: begin
                // A STOP accepted this cycle masks a coincident adv1.
                if (accept && (rx_data == CMD_STOP)) begin
                    state_d = IDLE;
                end else if (adv1 && (consumed_q != loaded_len_q)) begin
                    consumed_d = consumed_q + 13'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_input1_loader.sv
module tb_input1_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        in1_write;
    logic [12:0] addr_in;
    logic [11:0] data_in;
    logic        mem_rst;
    logic        adv1;
    logic        run;
    logic [12:0] loaded_len;
    logic [12:0] consumed;
    logic        in_empty;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int mark = -1;
    int first_cyc = 0;
    int last_cyc = 0;
    int data_bad = 0;
    logic chk_data = 1'b0;
    logic [12:0] last_addr = '0;
    int base;

    input1_loader dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .in1_write  (in1_write),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .mem_rst    (mem_rst),
        .adv1       (adv1),
        .run        (run),
        .loaded_len (loaded_len),
        .consumed   (consumed),
        .in_empty   (in_empty),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (in1_write) begin
            if (wr_cnt == mark) first_cyc = cyc;
            last_cyc  = cyc;
            last_addr = addr_in;
            if (chk_data && (data_in != addr_in[11:0])) data_bad++;
            wr_cnt++;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {7'd0, rx_ready, in1_write, addr_in, data_in, mem_rst, run,
                loaded_len, consumed, in_empty, busy};
    endfunction

    // Presents a byte and returns #1 after the edge that accepted it.
    task automatic send(input logic [7:0] b);
        logic done;
        done     = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
                break;
            end
        end
        rx_valid = 1'b0;
        if (!done) check_val("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        adv1     = 1'b0;

        // Reset held with random bus activity
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
            adv1     = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_val("reset_outs", all_outs(), 64'd0);
        end
        rx_valid = 1'b0;
        adv1     = 1'b0;
        check_val("reset_nowrite", 64'(wr_cnt), 64'd0);
        rst = 1'b1;
        #1;
        check_val("ready_pre_edge", 64'(rx_ready), 64'd0);
        tick();
        check_val("ready_post_edge", 64'(rx_ready), 64'd1);

        // Stray byte in IDLE is discarded
        send(8'h77);
        check_val("stray_busy", 64'(busy), 64'd0);

        // Load 3 words
        send(8'hA1);
        check_val("load_busy", 64'(busy), 64'd1);
        send(8'h00);
        send(8'h03);
        send(8'h34);
        send(8'hF2);
        check_val("w0", {31'd0, in1_write, 7'd0, addr_in, 12'd0, data_in}, {31'd0, 1'b1, 7'd0, 13'd0, 12'd0, 12'h234});
        send(8'h56);
        send(8'h01);
        check_val("w1", {31'd0, in1_write, 7'd0, addr_in, 12'd0, data_in}, {31'd0, 1'b1, 7'd0, 13'd1, 12'd0, 12'h156});
        send(8'hFF);
        send(8'h0F);
        check_val("w2", {31'd0, in1_write, 7'd0, addr_in, 12'd0, data_in}, {31'd0, 1'b1, 7'd0, 13'd2, 12'd0, 12'hFFF});
        check_val("w2_busy", 64'(busy), 64'd1);
        check_val("w2_ready", 64'(rx_ready), 64'd0);
        tick();
        check_val("load3_busy_fall", 64'(busy), 64'd0);
        check_val("load3_len", 64'(loaded_len), 64'd3);
        check_val("load3_wrcnt", 64'(wr_cnt), 64'd3);

        // Zero-length load, then a run
        base = wr_cnt;
        send(8'hA1);
        send(8'h00);
        send(8'h00);
        check_val("zlen_busy", 64'(busy), 64'd0);
        check_val("zlen_len", 64'(loaded_len), 64'd0);
        tick();
        check_val("zlen_nowrite", 64'(wr_cnt - base), 64'd0);
        send(8'h52);
        tick();
        check_val("zlen_run", 64'(run), 64'd1);
        check_val("zlen_empty", 64'(in_empty), 64'd1);
        send(8'h53);
        check_val("zlen_stop", 64'(run), 64'd0);

        // Run / consume on a 2-word load
        send(8'hA1);
        send(8'h00);
        send(8'h02);
        send(8'h11);
        send(8'h00);
        send(8'h22);
        send(8'h00);
        send(8'h52);
        check_val("run_memrst", {62'd0, mem_rst, run}, {62'd0, 1'b1, 1'b0});
        check_val("run_len", 64'(loaded_len), 64'd2);
        tick();
        check_val("run_start", {62'd0, mem_rst, run}, {62'd0, 1'b0, 1'b1});
        check_val("run_cons0", 64'(consumed), 64'd0);
        check_val("run_empty0", 64'(in_empty), 64'd0);
        adv1 = 1'b1; tick(); adv1 = 1'b0;
        check_val("cons1", 64'(consumed), 64'd1);
        check_val("empty1", 64'(in_empty), 64'd0);
        adv1 = 1'b1; tick(); adv1 = 1'b0;
        check_val("cons2", 64'(consumed), 64'd2);
        check_val("empty2", 64'(in_empty), 64'd1);
        adv1 = 1'b1; tick(); adv1 = 1'b0;
        check_val("cons_sat", 64'(consumed), 64'd2);
        send(8'hA1);
        check_val("run_load_ignored", {62'd0, busy, run}, {62'd0, 1'b0, 1'b1});
        send(8'h53);
        check_val("stop_run", 64'(run), 64'd0);
        check_val("stop_empty", 64'(in_empty), 64'd0);
        check_val("stop_cons_hold", 64'(consumed), 64'd2);
        adv1 = 1'b1; tick(); adv1 = 1'b0;
        check_val("adv_idle_ignored", 64'(consumed), 64'd2);

        // Reset mid-load after the LEN_LO byte
        send(8'hA1);
        send(8'h00);
        send(8'h05);
        #2;
        rst = 1'b0;
        #1;
        check_val("midrst_outs", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        base = wr_cnt;
        send(8'h34);
        tick();
        tick();
        check_val("midrst_nowrite", 64'(wr_cnt - base), 64'd0);
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_len", 64'(loaded_len), 64'd0);

        // Maximum length load with rx_valid held high
        base     = wr_cnt;
        mark     = wr_cnt;
        chk_data = 1'b1;
        send(8'hA1);
        send(8'h1F);
        send(8'hFF);
        for (int i = 0; i < 8191; i++) begin
            logic [12:0] w;
            w = 13'(i);
            send(w[7:0]);
            send({4'hF, w[11:8]});
        end
        tick();
        chk_data = 1'b0;
        check_val("max_wrcnt", 64'(wr_cnt - base), 64'd8191);
        check_val("max_last_addr", 64'(last_addr), 64'h1FFE);
        check_val("max_data", 64'(data_bad), 64'd0);
        check_val("max_rate", 64'(last_cyc - first_cyc), 64'(3 * 8190));
        check_val("max_len", 64'(loaded_len), 64'd8191);
        check_val("max_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
